// File: rtl/seq_pkg.sv
// Shared definitions for the note sequencer: state encoding, pattern size
// and the built-in 16-entry melody.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitRq = 2'd1,
        StSend   = 2'd2
    } seq_state_e;

    localparam int unsigned SeqLenMax = 16;

    // Entry 0 sits in the least-significant nibble.
    localparam logic [63:0] DefaultPattern = {
        4'd3, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd13, 4'd0,
        4'd13, 4'd12, 4'd10, 4'd8, 4'd6, 4'd5, 4'd3, 4'd1
    };

    function automatic logic [3:0] default_code(input logic [3:0] idx);
        return DefaultPattern[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/note_timer.sv
// Per-note duration counter: counts 0..NOTE_CYCLES-1 while enabled and
// flags the last cycle of each note with wrap.
module note_timer #(
    parameter int unsigned NOTE_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    localparam int unsigned CntW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(NOTE_CYCLES - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    assign wrap = enable && (r_cnt == CntMax);

    always_comb begin
        w_cnt_d = r_cnt;
        if (clear) begin
            w_cnt_d = '0;
        end else if (enable) begin
            w_cnt_d = wrap ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays a note pattern to a synthesizer, one code per data_rq handshake.
// Define SEQ_RAM_LOAD_EN to make the pattern writable while idle.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES = 12500000,
    parameter int unsigned SEQ_LEN     = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic       data_rq,
`ifdef SEQ_RAM_LOAD_EN
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
`endif
    output logic       data_rd,
    output logic [3:0] sound_code,
    output logic       busy,
    output logic [3:0] note_idx,
    output logic       done
);

    localparam logic [3:0] LastIdx = 4'(SEQ_LEN - 1);

    seq_state_e r_state;
    seq_state_e w_state_d;
    logic [3:0] r_idx;
    logic [3:0] w_idx_d;
    logic [3:0] r_code;
    logic [3:0] w_code_d;
    logic [3:0] w_pat_code;
    logic       r_done;
    logic       w_done_d;
    logic       w_clear;
    logic       w_busy;
    logic       w_wrap;
    logic       w_last_wrap;

    assign w_busy = (r_state != StIdle);

`ifdef SEQ_RAM_LOAD_EN
    logic [3:0] r_pattern [SeqLenMax];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SeqLenMax; i++) begin
                r_pattern[i] <= default_code(4'(i));
            end
        end else if (wr_en && (r_state == StIdle)) begin
            r_pattern[wr_addr] <= wr_data;
        end
    end

    assign w_pat_code = r_pattern[r_idx];
`else
    assign w_pat_code = default_code(r_idx);
`endif

    note_timer #(
        .NOTE_CYCLES(NOTE_CYCLES)
    ) u_timer (
        .clk    (CLOCK_50),
        .rst    (reset),
        .clear  (w_clear),
        .enable (w_busy),
        .wrap   (w_wrap)
    );

    assign w_last_wrap = w_wrap && (r_idx == LastIdx) && !loop;

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_code_d  = r_code;
        w_done_d  = 1'b0;
        w_clear   = 1'b0;
        if (stop) begin
            w_state_d = StIdle;
            w_idx_d   = 4'd0;
            w_clear   = 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        w_state_d = StWaitRq;
                        w_idx_d   = 4'd0;
                        w_clear   = 1'b1;
                    end
                end
                StWaitRq, StSend: begin
                    if (w_wrap) begin
                        w_idx_d = (r_idx == LastIdx) ? 4'd0 : r_idx + 4'd1;
                    end
                    // A final wrap during SEND still lets this SEND cycle complete.
                    if (w_last_wrap) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                        w_clear   = 1'b1;
                    end else if (r_state == StSend) begin
                        w_state_d = StWaitRq;
                    end else if (data_rq) begin
                        w_state_d = StSend;
                        w_code_d  = w_pat_code;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_idx_d   = 4'd0;
                    w_clear   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_idx   <= 4'd0;
            r_code  <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_code  <= w_code_d;
            r_done  <= w_done_d;
        end
    end

    assign data_rd    = (r_state == StSend);
    assign sound_code = data_rd ? r_code : 4'd0;
    assign busy       = w_busy;
    assign note_idx   = r_idx;
    assign done       = r_done;

endmodule
